regfile_wb_arbiter: RTL and testbench

// - Write-side controller for the register bank: merges writeback requests from the ALU and LSU

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter_skid_buf.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-bank writeback path.
// Pure definitions; no logic, no latency.
// Source identifiers index the per-source buffer and grant vectors.
package regfile_pkg;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  localparam int NUM_WB_SRC = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/decode bundle between the producers, decode and the write-side controller.
// Wires only; no latency.
// Each writeback source has its own valid/ready pair; ready is driven by the slave.
interface regfile_wb_arbiter_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
);

  logic              alu_valid;
  logic              alu_ready;
  logic [AWIDTH-1:0] alu_waddr;
  logic [DWIDTH-1:0] alu_wdata;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [AWIDTH-1:0] lsu_waddr;
  logic [DWIDTH-1:0] lsu_wdata;
  logic              issue_valid;
  logic [AWIDTH-1:0] issue_addr;
  logic [AWIDTH-1:0] raddr1;
  logic [AWIDTH-1:0] raddr2;
  logic              stall;
  logic              rf_wen;
  logic [AWIDTH-1:0] rf_waddr;
  logic [DWIDTH-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output issue_valid, issue_addr, raddr1, raddr2,
    input  alu_ready, lsu_ready, stall, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  issue_valid, issue_addr, raddr1, raddr2,
    output alu_ready, lsu_ready, stall, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_skid_buf.sv
// One-entry writeback holding register for a single source.
// Latency: handshake edge loads the entry; it is visible the following cycle.
// Ready when empty or being drained this cycle, so a drain and refill can overlap.
module wb_skid_buf #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              drain,
  output logic              buf_v,
  output logic [AWIDTH-1:0] buf_addr,
  output logic [DWIDTH-1:0] buf_data
);

  logic load;

  assign in_ready = !buf_v | drain;
  // x0 writes complete the handshake but never occupy the entry
  assign load     = in_valid & in_ready & (in_addr != '0);

  // Load has priority over drain so a same-cycle refill keeps the entry valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v    <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (load) begin
      buf_v    <= 1'b1;
      buf_addr <= in_addr;
      buf_data <= in_data;
    end else if (drain) begin
      buf_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU writebacks onto the single bank write port and tracks pending writes.
// Latency: 1 cycle handshake-to-write uncontested, 2 cycles when losing round-robin.
// Per-source ready = buffer empty or granted; stall flags reads of pending registers.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int NREG = 2 ** AWIDTH;

  logic [NUM_WB_SRC-1:0] buf_v;
  logic [NUM_WB_SRC-1:0] grant;
  logic [AWIDTH-1:0]     buf_addr [NUM_WB_SRC];
  logic [DWIDTH-1:0]     buf_data [NUM_WB_SRC];
  wb_src_e               rr_ptr;
  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       set_mask;
  logic [NREG-1:0]       clr_mask;
  logic                  wen;
  logic [AWIDTH-1:0]     waddr;
  logic [DWIDTH-1:0]     wdata;

  wb_skid_buf #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_alu_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.alu_valid),
    .in_ready (bus.alu_ready),
    .in_addr  (bus.alu_waddr),
    .in_data  (bus.alu_wdata),
    .drain    (grant[SRC_ALU]),
    .buf_v    (buf_v[SRC_ALU]),
    .buf_addr (buf_addr[SRC_ALU]),
    .buf_data (buf_data[SRC_ALU])
  );

  wb_skid_buf #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_lsu_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.lsu_valid),
    .in_ready (bus.lsu_ready),
    .in_addr  (bus.lsu_waddr),
    .in_data  (bus.lsu_wdata),
    .drain    (grant[SRC_LSU]),
    .buf_v    (buf_v[SRC_LSU]),
    .buf_addr (buf_addr[SRC_LSU]),
    .buf_data (buf_data[SRC_LSU])
  );

  // Grant the lone valid buffer, or the rr_ptr source when both hold a request
  always_comb begin
    grant = '0;
    if (&buf_v) begin
      grant[rr_ptr] = 1'b1;
    end else begin
      grant = buf_v;
    end
  end

  // Round-robin pointer only moves on a contested cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= SRC_ALU;
    end else if (&buf_v) begin
      rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

  // Write-port mux; idle port reads back as zero
  always_comb begin
    wen   = |grant;
    waddr = '0;
    wdata = '0;
    if (grant[SRC_ALU]) begin
      waddr = buf_addr[SRC_ALU];
      wdata = buf_data[SRC_ALU];
    end else if (grant[SRC_LSU]) begin
      waddr = buf_addr[SRC_LSU];
      wdata = buf_data[SRC_LSU];
    end
  end

  assign bus.rf_wen   = wen;
  assign bus.rf_waddr = waddr;
  assign bus.rf_wdata = wdata;

  // One-hot set/clear requests for the scoreboard this cycle
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid) set_mask[bus.issue_addr] = 1'b1;
    if (wen)             clr_mask[waddr]          = 1'b1;
  end

  // Set wins over clear so a newer producer keeps the register pending; x0 never pends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign bus.stall = pending[bus.raddr1] | pending[bus.raddr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner case, random vs model.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
// The model tracks held requests, a contest preference and a pending set.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.AWIDTH(3), .DWIDTH(8)) bus ();

  regfile_wb_arbiter #(.AWIDTH(3), .DWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       av;
    logic [2:0] aa;
    logic [7:0] ad;
    logic       lv;
    logic [2:0] la;
    logic [7:0] ld;
    logic       iv;
    logic [2:0] ia;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       wen;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       ardy;
    logic       lrdy;
    logic       stall;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[22];

  // reference model state
  logic       mv[2];
  logic [2:0] ma[2];
  logic [7:0] md[2];
  int         mpref;
  bit         mpend[8];
  int         mwin;

  function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                              input logic lv, input logic [2:0] la, input logic [7:0] ld,
                              input logic iv, input logic [2:0] ia,
                              input logic [2:0] r1, input logic [2:0] r2,
                              input logic wen, input logic [2:0] wa, input logic [7:0] wd,
                              input logic ardy, input logic lrdy, input logic stall);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2;
    v.wen = wen; v.wa = wa; v.wd = wd; v.ardy = ardy; v.lrdy = lrdy; v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic wen, input logic [2:0] wa,
                            input logic [7:0] wd, input logic ardy, input logic lrdy,
                            input logic stall);
    chk({tag, ".rf_wen"},    {31'd0, bus.rf_wen},    {31'd0, wen});
    chk({tag, ".rf_waddr"},  {29'd0, bus.rf_waddr},  {29'd0, wa});
    chk({tag, ".rf_wdata"},  {24'd0, bus.rf_wdata},  {24'd0, wd});
    chk({tag, ".alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, ardy});
    chk({tag, ".lsu_ready"}, {31'd0, bus.lsu_ready}, {31'd0, lrdy});
    chk({tag, ".stall"},     {31'd0, bus.stall},     {31'd0, stall});
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid   = v.av; bus.alu_waddr = v.aa; bus.alu_wdata = v.ad;
    bus.lsu_valid   = v.lv; bus.lsu_waddr = v.la; bus.lsu_wdata = v.ld;
    bus.issue_valid = v.iv; bus.issue_addr = v.ia;
    bus.raddr1      = v.r1; bus.raddr2 = v.r2;
  endtask

  // Which held request gets the port this cycle: -1 none, 0 ALU, 1 LSU
  function automatic int model_winner();
    if (mv[0] && mv[1]) return mpref;
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  task automatic model_check(input string tag);
    int w;
    logic ew;
    logic [2:0] ea;
    logic [7:0] ed;
    w  = model_winner();
    ew = (w >= 0);
    ea = ew ? ma[w] : 3'd0;
    ed = ew ? md[w] : 8'd0;
    check_outs(tag, ew, ea, ed, !mv[0] || (w == 0), !mv[1] || (w == 1),
               mpend[bus.raddr1] || mpend[bus.raddr2]);
  endtask

  // Apply one clock edge to the model using the inputs currently on the bus
  task automatic model_edge();
    int w;
    logic acc_a, acc_l;
    w     = model_winner();
    acc_a = bus.alu_valid && (!mv[0] || w == 0);
    acc_l = bus.lsu_valid && (!mv[1] || w == 1);
    if (w >= 0) mpend[ma[w]] = 1'b0;
    if (bus.issue_valid && bus.issue_addr != 3'd0) mpend[bus.issue_addr] = 1'b1;
    if (mv[0] && mv[1]) mpref = 1 - mpref;
    if (w >= 0) mv[w] = 1'b0;
    if (acc_a && bus.alu_waddr != 3'd0) begin
      mv[0] = 1'b1; ma[0] = bus.alu_waddr; md[0] = bus.alu_wdata;
    end
    if (acc_l && bus.lsu_waddr != 3'd0) begin
      mv[1] = 1'b1; ma[1] = bus.lsu_waddr; md[1] = bus.lsu_wdata;
    end
  endtask

  initial begin
    //          av aa ad     lv la ld     iv ia r1 r2  wen wa wd     ardy lrdy stall
    vt[0]  = mk(1, 3, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 3, 8'hA5, 1, 1, 0);
    vt[2]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 8'h11, 1, 0, 0);
    vt[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 2, 8'h22, 1, 1, 0);
    vt[5]  = mk(1, 1, 8'h33, 1, 2, 8'h44, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 2, 8'h44, 0, 1, 0);
    vt[7]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1, 8'h33, 1, 1, 0);
    vt[8]  = mk(1, 0, 8'h77, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[12] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 5, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[13] = mk(1, 5, 8'h55, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 8'h00, 1, 1, 1);
    vt[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  1, 5, 8'h55, 1, 1, 1);
    vt[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 5, 0,  0, 0, 8'h00, 1, 1, 0);
    vt[16] = mk(1, 4, 8'hAA, 0, 0, 8'h00, 1, 4, 0, 4,  0, 0, 8'h00, 1, 1, 0);
    vt[17] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 0, 4,  1, 4, 8'hAA, 1, 1, 1);
    vt[18] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4,  0, 0, 8'h00, 1, 1, 1);
    vt[19] = mk(1, 4, 8'hBB, 0, 0, 8'h00, 0, 0, 0, 4,  0, 0, 8'h00, 1, 1, 1);
    vt[20] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4,  1, 4, 8'hBB, 1, 1, 1);
    vt[21] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4,  0, 0, 8'h00, 1, 1, 0);

    // reset state
    rst = 1'b1;
    drive(vt[9]);
    #12;
    check_outs("reset", 0, 0, 8'h00, 1, 1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 22; i++) begin
      drive(vt[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vt[i].wen, vt[i].wa, vt[i].wd,
                 vt[i].ardy, vt[i].lrdy, vt[i].stall);
      @(posedge clk); #1;
    end

    // reset with both buffers holding requests
    drive(mk(1, 6, 8'h66, 1, 7, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(vt[9]);
    chk("full.rf_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("full.lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async.rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_async.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("rst_async.lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.rf_wen", i), {31'd0, bus.rf_wen}, 32'd0);
      @(posedge clk); #1;
    end

    // random traffic against the model, starting from the post-reset state
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0; ma[s] = 3'd0; md[s] = 8'd0;
    end
    mpref = 0;
    for (int r = 0; r < 8; r++) mpend[r] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.alu_valid   = ($urandom_range(0, 2) != 0);
      bus.alu_waddr   = 3'($urandom_range(0, 7));
      bus.alu_wdata   = 8'($urandom);
      bus.lsu_valid   = ($urandom_range(0, 2) != 0);
      bus.lsu_waddr   = 3'($urandom_range(0, 7));
      bus.lsu_wdata   = 8'($urandom);
      bus.issue_valid = ($urandom_range(0, 3) == 0);
      bus.issue_addr  = 3'($urandom_range(0, 7));
      bus.raddr1      = 3'($urandom_range(0, 7));
      bus.raddr2      = 3'($urandom_range(0, 7));
      @(negedge clk);
      model_check($sformatf("rnd%0d", c));
      @(posedge clk);
      model_edge();
      #1;
    end
    mwin = model_winner();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
